// File: rtl/johnson_phase_monitor_if.sv
// Signal bundle between a 4-bit Johnson counter source and its phase monitor.
// The master drives the sampled code; the slave returns decoded phase and health status.
interface johnson_phase_monitor_if #(
    parameter int REV_W = 8,
    parameter int ERR_W = 4
);
    logic [3:0]       q_in;
    logic [2:0]       phase;
    logic [7:0]       phase_onehot;
    logic             code_valid;
    logic             seq_err;
    logic             locked;
    logic [REV_W-1:0] rev_count;
    logic [ERR_W-1:0] err_count;

    modport master (
        output q_in,
        input  phase, phase_onehot, code_valid, seq_err, locked, rev_count, err_count
    );

    modport slave (
        input  q_in,
        output phase, phase_onehot, code_valid, seq_err, locked, rev_count, err_count
    );
endinterface

// File: rtl/johnson_phase_monitor.sv
// Decodes a sampled 4-bit Johnson code into phase / one-hot form, checks legality and
// sequence, tracks lock, and counts revolutions and errors. All outputs are registered.
module johnson_phase_monitor #(
    parameter int LOCK_COUNT = 4,
    parameter int REV_W      = 8,
    parameter int ERR_W      = 4,
    parameter int ALLOW_HOLD = 0
) (
    input  logic clk,
    input  logic reset,
    johnson_phase_monitor_if.slave bus
);
    typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;

    localparam logic [3:0] LC = LOCK_COUNT[3:0];

    // {legal, phase index}; illegal codes return 0 in the legal bit
    function automatic logic [3:0] decode(input logic [3:0] c);
        case (c)
            4'b0000: decode = 4'b1_000;
            4'b0001: decode = 4'b1_001;
            4'b0011: decode = 4'b1_010;
            4'b0111: decode = 4'b1_011;
            4'b1111: decode = 4'b1_100;
            4'b1110: decode = 4'b1_101;
            4'b1100: decode = 4'b1_110;
            4'b1000: decode = 4'b1_111;
            default: decode = 4'b0_000;
        endcase
    endfunction

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        sat_inc = (&v) ? v : v + 1'b1;
    endfunction

    state_t           r_state;
    logic [3:0]       r_good_cnt;
    logic [3:0]       r_prev_q;
    logic             r_have_prev;
    logic [2:0]       r_phase_p1;
    logic [7:0]       r_onehot_p1;
    logic             r_code_valid_p1;
    logic             r_seq_err_p1;
    logic             r_locked_p1;
    logic [REV_W-1:0] r_rev_p1;
    logic [ERR_W-1:0] r_err_p1;

    logic [3:0] w_dec;
    logic [3:0] w_prev_dec;
    logic       w_legal;
    logic [2:0] w_idx;
    logic [2:0] w_prev_idx;
    logic       w_check;
    logic       w_good;
    logic       w_seq_err;
    logic [3:0] w_cnt_next;
    logic       w_enter_lock;
    logic       w_rev_inc;

    assign w_dec      = decode(bus.q_in);
    assign w_prev_dec = decode(r_prev_q);
    assign w_legal    = w_dec[3];
    assign w_idx      = w_dec[2:0];
    assign w_prev_idx = w_prev_dec[2:0];

    // Sequence is judged only against a legal predecessor
    assign w_check      = r_have_prev && w_prev_dec[3] && w_legal;
    assign w_good       = w_check && ((w_idx == w_prev_idx + 3'd1) ||
                                      ((ALLOW_HOLD != 0) && (bus.q_in == r_prev_q)));
    assign w_seq_err    = !w_legal || (w_check && !w_good);
    assign w_cnt_next   = r_good_cnt + 4'd1;
    assign w_enter_lock = (r_state == ACQUIRE) && w_good && (w_cnt_next == LC);
    assign w_rev_inc    = w_good && (w_prev_idx == 3'd7) && (w_idx == 3'd0) &&
                          ((r_state == LOCKED) || w_enter_lock);

    // Stage p1: registered decode, status and lock FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= UNLOCKED;
            r_good_cnt      <= 4'd0;
            r_have_prev     <= 1'b0;
            r_phase_p1      <= 3'd0;
            r_onehot_p1     <= 8'd0;
            r_code_valid_p1 <= 1'b0;
            r_seq_err_p1    <= 1'b0;
            r_locked_p1     <= 1'b0;
            r_rev_p1        <= '0;
            r_err_p1        <= '0;
        end else begin
            r_prev_q        <= bus.q_in;
            r_have_prev     <= r_have_prev | w_legal;
            r_code_valid_p1 <= w_legal;
            r_seq_err_p1    <= w_seq_err;
            if (w_legal) begin
                r_phase_p1  <= w_idx;
                r_onehot_p1 <= 8'd1 << w_idx;
            end else begin
                r_onehot_p1 <= 8'd0;
            end
            if (w_seq_err) r_err_p1 <= sat_inc(r_err_p1);
            if (w_rev_inc) r_rev_p1 <= r_rev_p1 + 1'b1;

            if (!w_legal) begin
                r_state     <= UNLOCKED;
                r_good_cnt  <= 4'd0;
                r_locked_p1 <= 1'b0;
            end else if (w_seq_err) begin
                // Out-of-sequence legal code restarts acquisition from this code
                r_state     <= ACQUIRE;
                r_good_cnt  <= 4'd0;
                r_locked_p1 <= 1'b0;
            end else begin
                case (r_state)
                    UNLOCKED: begin
                        r_state    <= ACQUIRE;
                        r_good_cnt <= 4'd0;
                    end
                    ACQUIRE: begin
                        if (w_good) begin
                            r_good_cnt <= w_cnt_next;
                            if (w_cnt_next == LC) begin
                                r_state     <= LOCKED;
                                r_locked_p1 <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.phase        = r_phase_p1;
    assign bus.phase_onehot = r_onehot_p1;
    assign bus.code_valid   = r_code_valid_p1;
    assign bus.seq_err      = r_seq_err_p1;
    assign bus.locked       = r_locked_p1;
    assign bus.rev_count    = r_rev_p1;
    assign bus.err_count    = r_err_p1;
endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Scoreboard bench: two monitors (hold disallowed / allowed) share one Johnson stream;
// a phase-level reference model predicts every registered output.
module tb_johnson_phase_monitor;
    localparam int LOCK_COUNT = 4;
    localparam int REV_W      = 8;
    localparam int ERR_W      = 4;
    localparam int ERR_MAX    = (1 << ERR_W) - 1;
    localparam int REV_MOD    = 1 << REV_W;

    logic clk;
    logic reset;

    johnson_phase_monitor_if #(.REV_W(REV_W), .ERR_W(ERR_W)) if0 ();
    johnson_phase_monitor_if #(.REV_W(REV_W), .ERR_W(ERR_W)) if1 ();

    johnson_phase_monitor #(.LOCK_COUNT(LOCK_COUNT), .REV_W(REV_W), .ERR_W(ERR_W),
                            .ALLOW_HOLD(0)) dut0 (.clk(clk), .reset(reset), .bus(if0));
    johnson_phase_monitor #(.LOCK_COUNT(LOCK_COUNT), .REV_W(REV_W), .ERR_W(ERR_W),
                            .ALLOW_HOLD(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int phase;
        int onehot;
        int cv;
        int se;
        int locked;
        int rev;
        int err;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, one slot per monitor
    int m_prev[2];
    bit m_prev_legal[2];
    bit m_have[2];
    bit m_locked[2];
    int m_streak[2];   // -1: not acquiring; else good transitions since acquisition began
    int m_phase[2];
    int m_rev[2];
    int m_err[2];

    int ph;  // next phase the stimulus will present

    function automatic logic [3:0] code_of(input int p);
        int v;
        if (p <= 4) v = (1 << p) - 1;
        else        v = (15 << (p - 4)) & 15;
        return v[3:0];
    endfunction

    function automatic int index_of(input logic [3:0] c);
        int r = -1;
        for (int p = 0; p < 8; p++) if (code_of(p) == c) r = p;
        return r;
    endfunction

    task automatic model(input int k, input bit hold, input bit rst, input logic [3:0] code,
                         output exp_t e);
        int  idx, pidx;
        bit  check, good, se, wrap;
        if (rst) begin
            m_have[k] = 0; m_prev_legal[k] = 0; m_locked[k] = 0; m_streak[k] = -1;
            m_phase[k] = 0; m_rev[k] = 0; m_err[k] = 0;
            e = '{phase: 0, onehot: 0, cv: 0, se: 0, locked: 0, rev: 0, err: 0};
            return;
        end
        idx   = index_of(code);
        pidx  = index_of(m_prev[k][3:0]);
        check = m_have[k] && m_prev_legal[k] && (idx >= 0);
        good  = check && ((idx == (pidx + 1) % 8) || (hold && code == m_prev[k][3:0]));
        se    = (idx < 0) || (check && !good);
        wrap  = good && pidx == 7 && idx == 0;
        if (idx >= 0) m_phase[k] = idx;
        if (se) m_err[k] = (m_err[k] < ERR_MAX) ? m_err[k] + 1 : ERR_MAX;
        if (idx < 0) begin
            m_locked[k] = 0; m_streak[k] = -1;
        end else if (se) begin
            m_locked[k] = 0; m_streak[k] = 0;
        end else if (!m_locked[k]) begin
            if (m_streak[k] < 0) m_streak[k] = 0;
            else if (good) begin
                m_streak[k]++;
                if (m_streak[k] == LOCK_COUNT) m_locked[k] = 1;
            end
        end
        if (wrap && m_locked[k]) m_rev[k] = (m_rev[k] + 1) % REV_MOD;
        m_have[k]       = m_have[k] || (idx >= 0);
        m_prev[k]       = int'(code);
        m_prev_legal[k] = (idx >= 0);
        e.phase  = m_phase[k];
        e.onehot = (idx >= 0) ? (1 << idx) : 0;
        e.cv     = (idx >= 0);
        e.se     = se;
        e.locked = m_locked[k];
        e.rev    = m_rev[k];
        e.err    = m_err[k];
    endtask

    task automatic drive(input bit rst, input logic [3:0] code);
        exp_t e;
        @(negedge clk);
        reset    = rst;
        if0.q_in = code;
        if1.q_in = code;
        model(0, 1'b0, rst, code, e); sb0.push_back(e);
        model(1, 1'b1, rst, code, e); sb1.push_back(e);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, code_of(ph));
            ph = (ph + 1) % 8;
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    // Monitor: every edge presents a new registered result
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb0.size() > 0) begin
            e = sb0.pop_front();
            chk("h0.phase",  int'(if0.phase),        e.phase);
            chk("h0.onehot", int'(if0.phase_onehot), e.onehot);
            chk("h0.valid",  int'(if0.code_valid),   e.cv);
            chk("h0.seqerr", int'(if0.seq_err),      e.se);
            chk("h0.locked", int'(if0.locked),       e.locked);
            chk("h0.rev",    int'(if0.rev_count),    e.rev);
            chk("h0.err",    int'(if0.err_count),    e.err);
        end
        if (sb1.size() > 0) begin
            e = sb1.pop_front();
            chk("h1.phase",  int'(if1.phase),        e.phase);
            chk("h1.onehot", int'(if1.phase_onehot), e.onehot);
            chk("h1.valid",  int'(if1.code_valid),   e.cv);
            chk("h1.seqerr", int'(if1.seq_err),      e.se);
            chk("h1.locked", int'(if1.locked),       e.locked);
            chk("h1.rev",    int'(if1.rev_count),    e.rev);
            chk("h1.err",    int'(if1.err_count),    e.err);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        reset    = 1'b1;
        if0.q_in = 4'b0000;
        if1.q_in = 4'b0000;
        ph = 0;

        drive(1'b1, 4'b0000);
        drive(1'b1, 4'b0000);

        // Clean acquisition then several locked revolutions
        run(32);

        // Single illegal sample, then resume and relock
        drive(1'b0, 4'b0101);
        run(10);

        // Skip from 0011 straight to 1111
        while (ph != 3) run(1);
        drive(1'b0, code_of(4));
        ph = 5;
        run(8);

        // Hold 0111 for two samples
        while (ph != 4) run(1);
        drive(1'b0, code_of(3));
        run(8);

        // Twenty illegal samples interleaved with legal ones
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 4'b1010);
            run(1);
        end

        // Reset in the middle of a run
        run(3);
        drive(1'b1, code_of(ph));
        run(12);

        // Randomized mix of sequence, holds, glitches and resets
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2)        drive(1'b1, code_of(ph));
            else if (r < 9)   drive(1'b0, 4'($urandom_range(0, 15)));
            else if (r < 14)  drive(1'b0, code_of((ph + 7) % 8));
            else if (r < 16) begin
                ph = $urandom_range(0, 7);
                run(1);
            end else          run(1);
        end

        @(posedge clk);
        #3;
        chk("sb0.drained", sb0.size(), 0);
        chk("sb1.drained", sb1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
